int_to_real_conv: RTL and testbench

//   Converts a signed two's-complement integer to an IEEE-754 single-precision word.

---
 rtl/real_conv_pkg.sv | 24 ++
 rtl/real_round_unit.sv | 47 ++++
 rtl/int_to_real_conv.sv | 131 +++++++++++++
 tb/tb_int_to_real_conv.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/real_conv_pkg.sv
// rtl/real_conv_pkg.sv - shared types and constants for the integer to FP32 converter
// Holds the FP32 field widths and bias, the packed FP32 word layout and the
// converter FSM state encoding. Imported by int_to_real_conv and real_round_unit.
package real_conv_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    PACK,
    DONE
  } conv_state_t;

endpackage

// File: rtl/real_round_unit.sv
// rtl/real_round_unit.sv - combinational fraction rounding for FP32 packing
// Optional feature macro: ROUND_NEAREST_EN (round to nearest, ties to even).
// Without it the fraction is truncated toward zero.
// Ports:
//   frac_in   in   23  fraction taken from the normalised magnitude
//   guard     in   1   first bit below the fraction
//   sticky    in   1   OR of all bits below the guard bit
//   exp_in    in   8   biased exponent before rounding
//   frac_out  out  23  rounded fraction
//   exp_out   out  8   exponent after any rounding carry
import real_conv_pkg::*;

module real_round_unit (
  input  logic [FP32_MAN_W-1:0] frac_in,
  input  logic                  guard,
  input  logic                  sticky,
  input  logic [FP32_EXP_W-1:0] exp_in,
  output logic [FP32_MAN_W-1:0] frac_out,
  output logic [FP32_EXP_W-1:0] exp_out
);

`ifdef ROUND_NEAREST_EN
  logic                round_up;
  logic [FP32_MAN_W:0] frac_sum;

  // Ties go to the even fraction: a bare half rounds up only when frac is odd.
  assign round_up = guard & (sticky | frac_in[0]);
  assign frac_sum = {1'b0, frac_in} + {{FP32_MAN_W{1'b0}}, round_up};

  always_comb begin
    frac_out = frac_sum[FP32_MAN_W-1:0];
    exp_out  = exp_in;
    // All-ones fraction rolled over: the value reached the next power of two.
    if (frac_sum[FP32_MAN_W]) begin
      frac_out = '0;
      exp_out  = exp_in + FP32_EXP_W'(1);
    end
  end
`else
  logic round_bits_unused;

  assign round_bits_unused = guard | sticky;
  assign frac_out          = frac_in;
  assign exp_out           = exp_in;
`endif

endmodule

// File: rtl/int_to_real_conv.sv
// rtl/int_to_real_conv.sv - multi-cycle signed integer to IEEE-754 single converter
// Optional feature macro: ROUND_NEAREST_EN (selects round-to-nearest-even in
// real_round_unit; default build truncates toward zero).
// One conversion in flight. Sequence IDLE -> ABS -> NORM -> PACK -> DONE, with
// NORM shifting the magnitude left one bit per cycle until its msb is set.
// Ports:
//   clk        in   1       rising-edge clock
//   rst_n      in   1       synchronous reset, active-low
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       converter can accept an input (IDLE only)
//   in_data    in   INT_W   signed integer operand
//   out_valid  out  1       out_data holds a completed result
//   out_ready  in   1       consumer accepts out_data
//   out_data   out  32      {sign, exp[7:0], frac[22:0]}
import real_conv_pkg::*;

module int_to_real_conv #(
  parameter int INT_W = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data
);

  // Bits below the hidden one, widened with zero padding so that a guard bit
  // and at least one sticky bit always exist even for narrow integers.
  localparam int FW = INT_W - 1;
  localparam int EW = (FW < MAN_W + 2) ? (MAN_W + 2) : FW;

  conv_state_t        state, state_nxt;
  logic [INT_W-1:0]   mag;
  logic               sign_q;
  logic [EXP_W-1:0]   exp_q;

  logic [EW-1:0]      ext;
  logic [MAN_W-1:0]   pack_frac;
  logic               pack_guard;
  logic               pack_sticky;
  logic [MAN_W-1:0]   rnd_frac;
  logic [EXP_W-1:0]   rnd_exp;
  fp32_t              res;

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = ABS;
      ABS:  state_nxt = (mag == '0) ? DONE : NORM;
      NORM: if (mag[INT_W-1]) state_nxt = PACK;
      PACK: state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ext         = EW'(mag[FW-1:0]) << (EW - FW);
  assign pack_frac   = ext[EW-1 -: MAN_W];
  assign pack_guard  = ext[EW-MAN_W-1];
  assign pack_sticky = |ext[EW-MAN_W-2:0];

  real_round_unit u_round (
    .frac_in  (pack_frac),
    .guard    (pack_guard),
    .sticky   (pack_sticky),
    .exp_in   (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp)
  );

  assign res = '{sign: sign_q, exp: rnd_exp, frac: rnd_frac};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      mag       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag    <= in_data;
            sign_q <= in_data[INT_W-1];
          end
        end
        ABS: begin
          // Unsigned view makes the most negative input its own magnitude 2^(INT_W-1).
          if (sign_q) mag <= -mag;
          exp_q <= EXP_W'(FP32_BIAS + INT_W - 1);
          if (mag == '0) out_data <= '0;
        end
        NORM: begin
          if (!mag[INT_W-1]) begin
            mag   <= mag << 1;
            exp_q <= exp_q - EXP_W'(1);
          end
        end
        PACK: begin
          out_data <= res;
        end
        DONE: begin
          // Result word is already in place; raise valid one cycle after entry.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_real_conv.sv
// tb/tb_int_to_real_conv.sv - scoreboard bench for int_to_real_conv
module tb_int_to_real_conv;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int_to_real_conv #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus-side control (written only by the main initial block)
  int          ready_mode = 0;   // 0 always ready, 1 stalled, 2 random
  logic [31:0] pend_exp   = '0;
  int          pend_lat   = 0;
  int          idle_req   = 0;
  bit          idle_zero  = 1'b0;
  bit          stall_chk  = 1'b0;
  int          to_req     = 0;
  string       to_name    = "";
  bit          final_req  = 1'b0;

  // Monitor-side state (written only by the monitor)
  exp_t        q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          in_cnt   = 0;
  int          out_cnt  = 0;
  int          acc_cyc  = 0;
  int          idle_done = 0;
  int          to_done  = 0;
  bit          final_done = 1'b0;
  bit          seen     = 1'b0;
  logic [31:0] held     = '0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  function automatic void chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Scoreboard monitor: samples on the falling edge, between driver updates.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      in_cnt -= q.size();
      q.delete();
      seen = 1'b0;
    end else begin
      if (idle_req != idle_done) begin
        idle_done = idle_req;
        chk_int("idle_in_ready", int'(in_ready), 1);
        chk_int("idle_out_valid", int'(out_valid), 0);
        if (idle_zero) chk32("reset_out_data", out_data, 32'h0);
      end
      if (stall_chk) chk_int("stall_in_ready", int'(in_ready), 0);
      if (out_valid) begin
        if (!seen) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got 0x%08h expected no output", out_data);
          end else begin
            e = q.pop_front();
            chk32("out_data", out_data, e.data);
            chk_int("latency", cyc - acc_cyc, e.lat);
          end
          seen = 1'b1;
          held = out_data;
        end else begin
          chk32("out_stable", out_data, held);
        end
        if (out_ready) begin
          seen = 1'b0;
          out_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        e.data = pend_exp;
        e.lat  = pend_lat;
        q.push_back(e);
        acc_cyc = cyc + 1;
        in_cnt++;
      end
      if (to_req != to_done) begin
        to_done = to_req;
        checks++;
        errors++;
        $display("FAIL timeout_%s: got no event expected event within budget", to_name);
      end
      if (final_req && !final_done) begin
        final_done = 1'b1;
        chk_int("in_out_count", out_cnt, in_cnt);
        chk_int("queue_empty", q.size(), 0);
      end
    end
  end

  // Reference: exact double from $itor, narrowed to single by field arithmetic.
  function automatic void ref_model(input logic [31:0] v, output logic [31:0] bits, output int lat);
    real         r;
    logic [63:0] d;
    logic [51:0] f;
    logic [22:0] fr;
    logic [23:0] sum;
    int          e;
    bit          g, st;
    if (v == 32'h0) begin
      bits = 32'h0;
      lat  = 2;
      return;
    end
    r  = $itor($signed(v));
    d  = $realtobits(r);
    e  = int'(d[62:52]) - 1023;
    f  = d[51:0];
    fr = f[51:29];
    g  = f[28];
    st = |f[27:0];
    lat = (31 - e) + 4;
`ifdef ROUND_NEAREST_EN
    if (g && (st || fr[0])) begin
      sum = {1'b0, fr} + 24'd1;
      fr  = sum[22:0];
      if (sum[23]) e = e + 1;
    end
`else
    if (g || st) fr = fr;
`endif
    bits = {d[63], 8'(e + 127), fr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_exp = 0;

  task automatic send(input logic [31:0] v, input logic [31:0] ed, input int el);
    pend_exp = ed;
    pend_lat = el;
    in_data  = v;
    in_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        n_exp++;
        return;
      end
    end
    in_valid = 1'b0;
    to_name  = "send";
    to_req++;
    tick();
  endtask

  task automatic wait_out();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (out_cnt >= n_exp) begin
        tick();
        return;
      end
    end
    to_name = "output";
    to_req++;
    tick();
  endtask

  task automatic run_model(input logic [31:0] v);
    logic [31:0] b;
    int          l;
    ref_model(v, b, l);
    send(v, b, l);
  endtask

  initial begin
    logic [31:0] v;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    idle_zero = 1'b1;
    idle_req++;
    tick();
    tick();
    idle_zero = 1'b0;

    // Directed values with fixed expectations
    send(32'h0, 32'h0000_0000, 2);          wait_out();
    send(32'h1, 32'h3F80_0000, 35);         wait_out();
    send(32'hFFFF_FFFF, 32'hBF80_0000, 35); wait_out();
    send(32'h8000_0000, 32'hCF00_0000, 4);  wait_out();
`ifdef ROUND_NEAREST_EN
    send(32'd16777219, 32'h4B80_0002, 11);  wait_out();
    send(32'd2147483647, 32'h4F00_0000, 5); wait_out();
`else
    send(32'd16777219, 32'h4B80_0001, 11);  wait_out();
    send(32'd2147483647, 32'h4EFF_FFFF, 5); wait_out();
`endif
    send(32'd16777217, 32'h4B80_0000, 11);  wait_out();

    // Backpressure: hold the result, poke the input side meanwhile
    ready_mode = 1;
    tick();
    run_model(32'd1000);
    for (int i = 0; i < 200 && !out_valid; i++) tick();
    stall_chk = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      tick();
    end
    in_valid   = 1'b0;
    stall_chk  = 1'b0;
    ready_mode = 0;
    wait_out();

    // Reset in the middle of normalisation discards the conversion
    run_model(32'd5);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_exp--;
    idle_req++;
    tick();
    run_model(32'd12345);
    wait_out();
    run_model(32'hFFFF_CFC7);
    wait_out();

    // Random back-to-back stream with random consumer stalls
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 49) == 0) v = 32'h0;
      run_model(v);
    end
    ready_mode = 0;
    wait_out();

    final_req = 1'b1;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
